// File: rtl/multiword_adder_sequencer.sv
// multiword_adder_sequencer: drives one external BITS-wide adder slice
// LS slice first to add/subtract W=BITS*WORDS-bit operands.
// Ports: in_* request handshake (valid/ready, a, b, ci, sub);
//        out_* result handshake (valid/ready, s, co, ovf); busy;
//        add_a/add_b/add_ci to the slice, add_s/add_co back from it.
module multiword_adder_sequencer #(
  parameter int BITS  = 8,
  parameter int WORDS = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [BITS*WORDS-1:0] in_a,
  input  logic [BITS*WORDS-1:0] in_b,
  input  logic                  in_ci,
  input  logic                  in_sub,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [BITS*WORDS-1:0] out_s,
  output logic                  out_co,
  output logic                  out_ovf,
  output logic                  busy,
  output logic [BITS-1:0]       add_a,
  output logic [BITS-1:0]       add_b,
  output logic                  add_ci,
  input  logic [BITS-1:0]       add_s,
  input  logic                  add_co
);

  localparam int W  = BITS * WORDS;
  localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic [W-1:0]  s_q, s_d;
  logic          ci_q, ci_d;
  logic          carry_q, carry_d;
  logic          co_q, co_d;
  logic          ovf_q, ovf_d;

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    a_d       = a_q;
    b_d       = b_q;
    s_d       = s_q;
    ci_d      = ci_q;
    carry_d   = carry_q;
    co_d      = co_q;
    ovf_d     = ovf_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    add_a     = '0;
    add_b     = '0;
    add_ci    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          // Subtract is A + ~B + ~borrow; invert once at capture.
          a_d     = in_a;
          b_d     = in_b ^ {W{in_sub}};
          ci_d    = in_ci ^ in_sub;
          idx_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        add_a   = a_q[idx_q*BITS +: BITS];
        add_b   = b_q[idx_q*BITS +: BITS];
        add_ci  = (idx_q == '0) ? ci_q : carry_q;
        s_d[idx_q*BITS +: BITS] = add_s;
        carry_d = add_co;
        if (idx_q == LAST) begin
          // Top slice carry ends here; it never re-enters slice 0.
          co_d    = add_co;
          ovf_d   = (a_q[W-1] == b_q[W-1]) &&
                    (add_s[BITS-1] != a_q[W-1]);
          idx_d   = '0;
          state_d = DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      s_q     <= '0;
      ci_q    <= 1'b0;
      carry_q <= 1'b0;
      co_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      a_q     <= a_d;
      b_q     <= b_d;
      s_q     <= s_d;
      ci_q    <= ci_d;
      carry_q <= carry_d;
      co_q    <= co_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_s   = s_q;
  assign out_co  = co_q;
  assign out_ovf = ovf_q;
  assign busy    = (state_q != IDLE);

endmodule

// File: tb/tb_multiword_adder_sequencer.sv
// tb_multiword_adder_sequencer: four sequencer instances, each with a
// combinational adder slice; directed and random ops vs a scoreboard.
module tb_multiword_adder_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        iv;
  logic        ci;
  logic        sub;
  logic        ordy;
  logic [63:0] ia;
  logic [63:0] ib;
  int          sel;

  logic [3:0][63:0] o_s;
  logic [3:0][63:0] a_mon;
  logic [3:0]       o_v, o_co, o_ovf, i_rdy, bsy, aci, aco;

  int checks = 0;
  int errors = 0;

  logic [63:0] co_tr;
  logic [63:0] ci_tr;

  typedef struct packed {
    logic [63:0] s;
    logic        co;
    logic        ovf;
  } exp_t;

  exp_t sb[$];

  function automatic int nb(int g);
    case (g)
      0: return 8;
      1: return 8;
      2: return 16;
      default: return 1;
    endcase
  endfunction

  function automatic int nw(int g);
    case (g)
      0: return 4;
      1: return 1;
      2: return 3;
      default: return 3;
    endcase
  endfunction

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int B = nb(g);
    localparam int N = nw(g);
    localparam int W = B * N;
    logic [B-1:0] add_a, add_b, add_s;
    logic         add_ci, add_co;
    logic [W-1:0] s;
    logic         v, co, ovf, rdy, bz;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b}
                           + {{B{1'b0}}, add_ci};

    multiword_adder_sequencer #(.BITS(B), .WORDS(N)) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .in_valid (iv && (sel == g)),
      .in_ready (rdy),
      .in_a     (ia[W-1:0]),
      .in_b     (ib[W-1:0]),
      .in_ci    (ci),
      .in_sub   (sub),
      .out_valid(v),
      .out_ready(ordy),
      .out_s    (s),
      .out_co   (co),
      .out_ovf  (ovf),
      .busy     (bz),
      .add_a    (add_a),
      .add_b    (add_b),
      .add_ci   (add_ci),
      .add_s    (add_s),
      .add_co   (add_co)
    );

    assign o_s[g]   = 64'(s);
    assign a_mon[g] = 64'({add_a, add_b});
    assign o_v[g]   = v;
    assign o_co[g]  = co;
    assign o_ovf[g] = ovf;
    assign i_rdy[g] = rdy;
    assign bsy[g]   = bz;
    assign aci[g]   = add_ci;
    assign aco[g]   = add_co;
  end

  // W+1-bit reference for instance g.
  function automatic exp_t model(int g, logic [63:0] a, logic [63:0] b,
                                 logic c, logic su);
    int          w;
    logic [64:0] m, bb, sum;
    exp_t        e;
    w     = nb(g) * nw(g);
    m     = (65'd1 << w) - 65'd1;
    bb    = {1'b0, (su ? ~b : b)} & m;
    sum   = ({1'b0, a} & m) + bb + {64'd0, c ^ su};
    e.s   = sum[63:0] & m[63:0];
    e.co  = sum[w];
    e.ovf = (a[w-1] == bb[w-1]) && (e.s[w-1] != a[w-1]);
    return e;
  endfunction

  task automatic do_op(input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic su, input exp_t e,
                       output int lat);
    exp_t got;
    exp_t want;
    int   t;
    ia  = a;
    ib  = b;
    ci  = c;
    sub = su;
    iv  = 1'b1;
    t   = 0;
    while (!i_rdy[sel] && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (!i_rdy[sel]) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout inst=%0d", sel);
    end
    sb.push_back(e);
    @(negedge clk);
    iv  = 1'b0;
    lat = 0;
    while (!o_v[sel] && lat < 50) begin
      co_tr[lat] = aco[sel];
      ci_tr[lat] = aci[sel];
      lat++;
      @(negedge clk);
    end
    checks++;
    if (lat !== nw(sel)) begin
      errors++;
      $display("FAIL latency inst=%0d got=%0d want=%0d",
               sel, lat, nw(sel));
    end
    if (o_v[sel]) begin
      checks++;
      got = {o_s[sel], o_co[sel], o_ovf[sel]};
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL result_unexpected inst=%0d got=%h", sel, got.s);
      end else begin
        want = sb.pop_front();
        if (got !== want) begin
          errors++;
          $display("FAIL result inst=%0d got s=%h co=%b ovf=%b want s=%h co=%b ovf=%b",
                   sel, got.s, got.co, got.ovf, want.s, want.co, want.ovf);
        end
      end
      if (ordy) begin
        @(negedge clk);
        checks++;
        if (o_v[sel] !== 1'b0 || i_rdy[sel] !== 1'b1) begin
          errors++;
          $display("FAIL release inst=%0d valid=%b ready=%b want 0 1",
                   sel, o_v[sel], i_rdy[sel]);
        end
      end
    end
  endtask

  task automatic check_reset_vals(input string tag);
    for (int g = 0; g < 4; g++) begin
      checks++;
      if (i_rdy[g] !== 1'b1 || o_v[g] !== 1'b0 || o_s[g] !== 64'd0 ||
          o_co[g] !== 1'b0 || o_ovf[g] !== 1'b0 || bsy[g] !== 1'b0 ||
          a_mon[g] !== 64'd0 || aci[g] !== 1'b0) begin
        errors++;
        $display("FAIL %s inst=%0d rdy=%b v=%b s=%h co=%b ovf=%b busy=%b want 1 0 0 0 0 0",
                 tag, g, i_rdy[g], o_v[g], o_s[g], o_co[g], o_ovf[g], bsy[g]);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    check_reset_vals("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_carry_chain();
    int lat;
    sel  = 0;
    ordy = 1'b1;
    do_op(64'hFFFFFFFF, 64'h1, 1'b0, 1'b0, '{64'h0, 1'b1, 1'b0}, lat);
    checks++;
    if (co_tr[3:0] !== 4'hF) begin
      errors++;
      $display("FAIL carry_chain got=%b want=1111", co_tr[3:0]);
    end
  endtask

  task automatic test_subtract();
    int lat;
    sel = 0;
    do_op(64'h5, 64'h7, 1'b0, 1'b1, '{64'hFFFFFFFE, 1'b0, 1'b0}, lat);
    do_op(64'h80000000, 64'h1, 1'b0, 1'b1, '{64'h7FFFFFFF, 1'b1, 1'b1}, lat);
  endtask

  task automatic test_carry_in();
    int lat;
    sel = 0;
    do_op(64'h7FFFFFFF, 64'h0, 1'b1, 1'b0, '{64'h80000000, 1'b0, 1'b1}, lat);
    do_op(64'hFF, 64'h1, 1'b0, 1'b0, '{64'h100, 1'b0, 1'b0}, lat);
    checks++;
    if (ci_tr[2:0] !== 3'b010) begin
      errors++;
      $display("FAIL slice_carry_in got=%b want=010", ci_tr[2:0]);
    end
  endtask

  task automatic test_backpressure();
    int          lat;
    logic [63:0] s0;
    logic        c0, v0;
    sel  = 0;
    ordy = 1'b0;
    do_op(64'hF0, 64'h10, 1'b0, 1'b0, '{64'h100, 1'b0, 1'b0}, lat);
    s0 = o_s[0];
    c0 = o_co[0];
    v0 = o_ovf[0];
    for (int i = 0; i < 5; i++) begin
      iv = ~iv;
      ia = {$urandom, $urandom};
      @(negedge clk);
      checks++;
      if (o_s[0] !== s0 || o_co[0] !== c0 || o_ovf[0] !== v0 ||
          i_rdy[0] !== 1'b0 || o_v[0] !== 1'b1 || a_mon[0] !== 64'd0) begin
        errors++;
        $display("FAIL hold cyc=%0d s=%h rdy=%b v=%b want s=%h rdy=0 v=1",
                 i, o_s[0], i_rdy[0], o_v[0], s0);
      end
    end
    iv   = 1'b0;
    ordy = 1'b1;
    @(negedge clk);
    checks++;
    if (o_v[0] !== 1'b0 || i_rdy[0] !== 1'b1) begin
      errors++;
      $display("FAIL bp_release v=%b rdy=%b want 0 1", o_v[0], i_rdy[0]);
    end
    do_op(64'h1, 64'h2, 1'b0, 1'b0, '{64'h3, 1'b0, 1'b0}, lat);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_leftover got=%0d want=0", sb.size());
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    sel = 0;
    ia  = 64'hDEADBEEF;
    ib  = 64'h01010101;
    ci  = 1'b0;
    sub = 1'b0;
    iv  = 1'b1;
    @(negedge clk);
    iv = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_reset_vals("reset_mid");
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (o_v[0] !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_valid got=%b want=0", o_v[0]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
    do_op(64'h12345678, 64'h11111111, 1'b0, 1'b0,
          '{64'h23456789, 1'b0, 1'b0}, lat);
  endtask

  task automatic test_words1();
    int lat;
    sel = 1;
    do_op(64'hFF, 64'h1, 1'b0, 1'b0, '{64'h0, 1'b1, 1'b0}, lat);
  endtask

  task automatic test_random();
    int          lat;
    logic [63:0] a, b;
    logic        c, su;
    for (int g = 0; g < 4; g++) begin
      sel = g;
      for (int i = 0; i < 12; i++) begin
        a  = {$urandom, $urandom};
        b  = {$urandom, $urandom};
        c  = 1'($urandom_range(0, 1));
        su = 1'($urandom_range(0, 1));
        do_op(a, b, c, su, model(g, a, b, c, su), lat);
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    iv    = 1'b0;
    ia    = '0;
    ib    = '0;
    ci    = 1'b0;
    sub   = 1'b0;
    ordy  = 1'b1;
    sel   = 0;
    co_tr = '0;
    ci_tr = '0;
    test_reset();
    test_carry_chain();
    test_subtract();
    test_carry_in();
    test_backpressure();
    test_reset_mid();
    test_words1();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multiword_adder_sequencer.md
Name: multiword_adder_sequencer

Overview:
- Sequences one shared BITS-wide parallel-prefix adder slice (the Kogge-Stone adder instance sits outside this block) to add or subtract WORDS*BITS-bit operands, least-significant slice first, one slice per cycle.
- The slice carry-out is registered between slices.
- Operands enter on a valid/ready handshake, and the result is held on a valid/ready output handshake.
- Sits between the ALU issue logic and the adder instance.

Parameters:
BITS, 8, width of the external adder slice (1..128)
WORDS, 4, number of slices per operand (>=1); W = BITS*WORDS is the operand width

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous, active-low reset
in_valid  input  1  operand request valid
in_ready  output  1  block can accept a request
in_a  input  W  operand A
in_b  input  W  operand B
in_ci  input  1  carry-in (borrow-in when in_sub=1)
in_sub  input  1  1 = subtract (A - B - in_ci), 0 = add (A + B + in_ci)
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_s  output  W  sum/difference
out_co  output  1  final carry-out (for subtract, 1 = no borrow)
out_ovf  output  1  two's-complement overflow
busy  output  1  state != IDLE
add_a  output  BITS  to adder a
add_b  output  BITS  to adder b
add_ci  output  1  to adder ci
add_s  input  BITS  from adder s
add_co  input  1  from adder co

Behaviour:
- Reset state (async assert): state=IDLE, idx=0, carry_reg=0, and all operand/result registers cleared. Outputs: in_ready=1, out_valid=0, out_s=0, out_co=0, out_ovf=0, busy=0.
- The adder is external and purely combinational. add_s/add_co are sampled on the same edge that the corresponding add_a/add_b/add_ci are presented.
- FSM, IDLE -> RUN:
  - in_ready=1 only in IDLE.
  - On in_valid&&in_ready at an edge, latch a_reg=in_a, b_reg=in_b^{W{in_sub}}, ci_reg=in_ci^in_sub; set idx=0; go to RUN.
- FSM, RUN:
  - Drive add_a=a_reg[idx*BITS+:BITS], add_b=b_reg[idx*BITS+:BITS].
  - add_ci = ci_reg when idx==0, else carry_reg.
  - At each edge: s_reg[idx*BITS+:BITS]<=add_s; carry_reg<=add_co; idx<=idx+1.
  - At idx==WORDS-1, also latch out_co<=add_co and out_ovf<=(a_msb==b_msb)&&(add_s[BITS-1]!=a_msb), where a_msb/b_msb are bit W-1 of a_reg/b_reg. Go to DONE; idx returns to 0.
- FSM, DONE:
  - out_valid=1; out_s, out_co and out_ovf are held stable.
  - On out_valid&&out_ready, go to IDLE (out_valid drops the next cycle).
  - No same-cycle accept from DONE.
- add_a/add_b/add_ci are 0 outside RUN.
- Latency: out_valid rises exactly WORDS cycles after the accept edge. Minimum initiation interval is WORDS+2 cycles with out_ready tied high.
- WORDS=1: RUN lasts one cycle; add_ci=ci_reg.
- in_valid while not IDLE: ignored, no side effects. Input data changes after acceptance do not affect the result.
- out_ready while not DONE: ignored.
- Carry wrap: the carry out of the top slice goes only to out_co and never feeds back.
- idx is $clog2(WORDS) bits (min 1) and never exceeds WORDS-1.
- Reset mid-RUN or mid-DONE: immediate abort, all state returns to reset values, the partial result is discarded, and no out_valid pulse occurs.

Test Plan:
- BITS=8, WORDS=4: A=0xFFFFFFFF, B=0x00000001, ci=0, sub=0 -> add_co=1 on idx 0..3; out_s=0x00000000, out_co=1, out_ovf=0; out_valid exactly 4 cycles after accept.
- Subtract: A=0x00000005, B=0x00000007, ci=0, sub=1 -> out_s=0xFFFFFFFE, out_co=0, out_ovf=0. Then A=0x80000000, B=0x00000001, sub=1 -> out_s=0x7FFFFFFF, out_co=1, out_ovf=1.
- Carry-in/overflow: A=0x7FFFFFFF, B=0, ci=1, sub=0 -> out_s=0x80000000, out_co=0, out_ovf=1. Also A=0x000000FF, B=0x01 -> add_ci=1 at idx=1, out_s=0x00000100.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid/in_a -> out_s/out_co/out_ovf stable, in_ready=0, no new accept. Release -> IDLE next cycle, then the next request is accepted and correct.
- Reset mid-operation: assert rst_n=0 while idx=2 -> all outputs equal reset values asynchronously, no out_valid. After release, 0x12345678+0x11111111 -> 0x23456789, out_co=0.
- Parameter sweep: WORDS=1, BITS=8, A=0xFF, B=0x01 -> out_s=0x00, out_co=1, latency 1 cycle. Random operands for BITS in {1,8,16}, WORDS in {1,3,4} checked against a W+1-bit reference model.
